reg_file_mp: RTL and testbench
==============================

Name: reg_file_mp

Overview:
- Parametrised multi-port successor to the CPU's 24-bit x16 register file.
- Provides NUM_RD combinational read ports, one ALU write port and a load-writeback port with a valid/ready handshake.
- Provides a store channel: a 2-state FSM snapshots a register and holds it for the memory stage until it is accepted.
- Sits between the decode/execute stages and the data-memory interface.

Parameters:
- DATA_W, 24, register width in bits
- DEPTH, 16, number of registers
- ADDR_W, $clog2(DEPTH), register address width
- NUM_RD, 2, number of combinational read ports
- ZERO_REG, 1, 1 = register 0 reads as 0 and ignores all writes
- BYPASS, 1, 1 = same-cycle write data is forwarded to read ports and to the store snapshot

Ports:
- reg_clk  in  1  global clock; all state on rising edge
- reg_rst  in  1  global reset, asynchronous, active-low
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port i = bits [i*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  packed read data, same packing
- wr_en  in  1  ALU write enable
- wr_addr  in  ADDR_W  ALU write address
- wr_data  in  DATA_W  ALU write data
- ld_valid  in  1  memory-to-register write request
- ld_ready  out  1  load accepted this cycle when high with ld_valid
- ld_addr  in  ADDR_W  load destination register
- ld_data  in  DATA_W  load data
- st_req  in  1  single-cycle request to send a register to memory
- st_addr  in  ADDR_W  source register for the store
- st_valid  out  1  store data valid to memory
- st_ready  in  1  memory accepts store data
- st_data  out  DATA_W  registered store data
- st_busy  out  1  store FSM in HOLD; st_req is ignored while high

Behaviour:
- Clocking and reset (already decided): one clock; reset is asynchronous and active-low.
- Reset: reg_rst low clears all DEPTH registers to 0, st_valid=0, st_data=0, st_busy=0 and the FSM to IDLE, immediately, regardless of reg_clk.
- ld_ready is 0 while in reset.
- Reset mid-store abandons the transfer; st_valid drops asynchronously and nothing is replayed.
- Reads: combinational, zero latency. Priority per port:
  - ZERO_REG && addr==0 -> 0.
  - Else, if BYPASS and wr_en && wr_addr==addr -> wr_data.
  - Else, if BYPASS and (ld_valid && ld_ready && ld_addr==addr) -> ld_data.
  - Else, the stored value.
- Writes: commit on the rising edge of reg_clk.
  - Different addresses: the ALU and load writes both commit in the same cycle.
- Write conflict: if wr_en && ld_valid && wr_addr==ld_addr, then ld_ready=0 that cycle.
  - The ALU write commits.
  - The load must hold ld_valid/ld_addr/ld_data and retries; it is accepted the next cycle the conflict is absent.
- Otherwise ld_ready=1 whenever reset is deasserted. ld_ready never depends on st_* signals.
- Writes to register 0 are dropped when ZERO_REG=1; ld_ready is still 1, so the handshake completes.
- Store FSM states: IDLE, HOLD.
  - IDLE & st_req: st_data <= read value of st_addr using the read-priority rules above, so BYPASS applies. Then st_valid<=1, st_busy<=1, go to HOLD. Latency is 1 cycle from st_req to st_valid.
  - HOLD: st_data and st_valid are stable until st_ready.
  - HOLD & st_ready: st_valid<=0, st_busy<=0, go to IDLE.
  - st_req in HOLD, including the st_ready cycle, is ignored. Minimum store spacing is 2 cycles.
  - A later register write to st_addr while in HOLD does not change st_data.
- All arithmetic is unsigned. Address values >= DEPTH (non-power-of-2 DEPTH) read 0 and are not written.

Decomposition:
- reg_file_pkg holds:
  - store FSM state encodings ST_IDLE=1'b0, ST_HOLD=1'b1;
  - default DATA_W/DEPTH constants;
  - a function for the ADDR_W computation.
- One sub-module, reg_file_store_fsm, owns the IDLE/HOLD state, st_valid/st_busy/st_data and the snapshot capture. It takes the resolved read value as an input.
- The storage array, read muxes, bypass and conflict logic stay in reg_file_mp.

Test Plan:
- Reset: hold reg_rst=0 for 2 cycles, release, read all 16 addresses -> every rd_data=0, st_valid=0, ld_ready=1.
- ALU write then read:
  - wr_en, r5=24'hABCDEF; same cycle rd_addr[0]=5 -> 24'hABCDEF (bypass).
  - Next cycle, with wr_en=0, rd_data[0] still reads 24'hABCDEF.
- Register 0 with ZERO_REG=1: write r0=24'h123456 -> rd_data reads 0; ld_valid to r0 -> ld_ready=1 and r0 stays 0.
- Load/ALU conflict:
  - Same cycle: wr_en r3=24'h000011 and ld_valid r3=24'h000022 -> ld_ready=0.
  - Next cycle, with wr_en=0, ld_ready=1 -> r3 ends at 24'h000022.
  - Simultaneous writes r3/r4 both commit.
- Store handshake:
  - Set r7=24'h5A5A5A, pulse st_req addr 7 -> st_valid=1 one cycle later with st_data=24'h5A5A5A.
  - Hold st_ready=0 for 3 cycles while writing r7=0 and pulsing st_req -> st_data unchanged, st_busy=1.
  - st_ready=1 -> st_valid=0 the next cycle.
- Reset mid-store: assert reg_rst low while in HOLD between clock edges -> st_valid and st_busy drop immediately; after release the FSM is IDLE and a new st_req works.

Source files
------------

// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared constants, store FSM encoding and address-width helper
package reg_file_pkg;
  localparam int DATA_W_DEF = 24;
  localparam int DEPTH_DEF = 16;
  typedef enum logic {ST_IDLE = 1'b0, ST_HOLD = 1'b1} st_state_t;
  function automatic int addr_w(input int depth);
    return depth <= 1 ? 1 : $clog2(depth);
  endfunction
endpackage

// File: rtl/reg_file_if.sv
// reg_file_if: read, ALU write, load-writeback and store channels of the register file
interface reg_file_if #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 4,
  parameter int NUM_RD = 2
);
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic ld_valid;
  logic ld_ready;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic st_req;
  logic [ADDR_W-1:0] st_addr;
  logic st_valid;
  logic st_ready;
  logic [DATA_W-1:0] st_data;
  logic st_busy;
  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, ld_valid, ld_addr, ld_data, st_req, st_addr, st_ready,
    input rd_data, ld_ready, st_valid, st_data, st_busy
  );
  modport slave (
    input rd_addr, wr_en, wr_addr, wr_data, ld_valid, ld_addr, ld_data, st_req, st_addr, st_ready,
    output rd_data, ld_ready, st_valid, st_data, st_busy
  );
endinterface

// File: rtl/reg_file_store_fsm.sv
// reg_file_store_fsm: snapshots a resolved register value and holds it until memory accepts it
module reg_file_store_fsm
  import reg_file_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic reg_clk,
  input  logic reg_rst,
  input  logic st_req,
  input  logic st_ready,
  input  logic [DATA_W-1:0] rd_val,
  output logic st_valid,
  output logic st_busy,
  output logic [DATA_W-1:0] st_data
);
  st_state_t state;
  always_ff @(posedge reg_clk or negedge reg_rst) begin
    if (!reg_rst) begin
      state <= ST_IDLE;
      st_valid <= 1'b0;
      st_busy <= 1'b0;
      st_data <= '0;
    end else if (state == ST_IDLE) begin
      if (st_req) begin
        st_data <= rd_val;
        st_valid <= 1'b1;
        st_busy <= 1'b1;
        state <= ST_HOLD;
      end
    end else if (st_ready) begin
      st_valid <= 1'b0;
      st_busy <= 1'b0;
      state <= ST_IDLE;
    end
  end
endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port register file with forwarding, load handshake and store channel
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int ADDR_W = addr_w(DEPTH),
  parameter int NUM_RD = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS = 1
) (
  input logic reg_clk,
  input logic reg_rst,
  reg_file_if.slave bus
);
  logic [DATA_W-1:0] regs [DEPTH];
  logic [ADDR_W-1:0] ra [NUM_RD+1];
  logic [DATA_W-1:0] rv [NUM_RD+1];
  logic ld_ready, ld_fire;
  function automatic logic writable(input logic [ADDR_W-1:0] a);
    return int'(a) < DEPTH && !(ZERO_REG != 0 && a == '0);
  endfunction
  // the ALU wins a same-register collision; the load retries next cycle
  assign ld_ready = reg_rst && !(bus.wr_en && bus.ld_valid && bus.wr_addr == bus.ld_addr);
  assign ld_fire = bus.ld_valid && ld_ready;
  assign bus.ld_ready = ld_ready;
  assign ra[NUM_RD] = bus.st_addr;
  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    assign ra[g] = bus.rd_addr[g*ADDR_W +: ADDR_W];
    assign bus.rd_data[g*DATA_W +: DATA_W] = rv[g];
  end
  // the extra port resolves the store source with the same forwarding rules
  for (genvar g = 0; g <= NUM_RD; g++) begin : g_res
    assign rv[g] = !writable(ra[g]) ? '0 :
                   BYPASS != 0 && bus.wr_en && bus.wr_addr == ra[g] ? bus.wr_data :
                   BYPASS != 0 && ld_fire && bus.ld_addr == ra[g] ? bus.ld_data :
                   regs[ra[g]];
  end
  always_ff @(posedge reg_clk or negedge reg_rst) begin
    if (!reg_rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      if (bus.wr_en && writable(bus.wr_addr)) regs[bus.wr_addr] <= bus.wr_data;
      if (ld_fire && writable(bus.ld_addr)) regs[bus.ld_addr] <= bus.ld_data;
    end
  end
  reg_file_store_fsm #(.DATA_W(DATA_W)) u_store (
    .reg_clk(reg_clk),
    .reg_rst(reg_rst),
    .st_req(bus.st_req),
    .st_ready(bus.st_ready),
    .rd_val(rv[NUM_RD]),
    .st_valid(bus.st_valid),
    .st_busy(bus.st_busy),
    .st_data(bus.st_data)
  );
endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: directed stimulus with a queue-based scoreboard checked by separate monitors
module tb_reg_file_mp;
  typedef struct {
    string name;
    int sel;
    logic [23:0] exp;
  } chk_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;
  chk_t q[$];
  logic [23:0] sq[$];
  logic prev_valid = 1'b0;
  reg_file_if #(.DATA_W(24), .ADDR_W(4), .NUM_RD(2)) bus ();
  reg_file_mp #(.DATA_W(24), .DEPTH(16), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1)) dut (
    .reg_clk(clk),
    .reg_rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic expect_val(input string name, input int sel, input logic [23:0] exp);
    chk_t c;
    c.name = name;
    c.sel = sel;
    c.exp = exp;
    q.push_back(c);
  endtask
  task automatic rd(input logic [3:0] a0, input logic [3:0] a1);
    bus.rd_addr = {a1, a0};
  endtask
  task automatic wr(input logic en, input logic [3:0] a, input logic [23:0] d);
    bus.wr_en = en;
    bus.wr_addr = a;
    bus.wr_data = d;
  endtask
  task automatic ld(input logic v, input logic [3:0] a, input logic [23:0] d);
    bus.ld_valid = v;
    bus.ld_addr = a;
    bus.ld_data = d;
  endtask
  task automatic st(input logic req, input logic [3:0] a, input logic rdy);
    bus.st_req = req;
    bus.st_addr = a;
    bus.st_ready = rdy;
  endtask
  // sampled mid-cycle, well away from the rising edge
  always @(negedge clk) begin
    chk_t c;
    logic [23:0] act;
    while (q.size() > 0) begin
      c = q.pop_front();
      case (c.sel)
        0: act = bus.rd_data[23:0];
        1: act = bus.rd_data[47:24];
        2: act = {23'd0, bus.ld_ready};
        3: act = {23'd0, bus.st_valid};
        4: act = bus.st_data;
        default: act = {23'd0, bus.st_busy};
      endcase
      checks++;
      if (act !== c.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h", c.name, act, c.exp);
      end
    end
    if (bus.st_valid === 1'b1 && !prev_valid) begin
      checks++;
      if (sq.size() == 0) begin
        errors++;
        $display("FAIL st_unexpected: got data %h expected no store", bus.st_data);
      end else if (bus.st_data !== sq[0]) begin
        errors++;
        $display("FAIL st_snapshot: got %h expected %h", bus.st_data, sq.pop_front());
      end else void'(sq.pop_front());
    end
    prev_valid = bus.st_valid === 1'b1;
  end
  initial begin
    rd(0, 0);
    wr(0, 0, 0);
    ld(0, 0, 0);
    st(0, 0, 0);
    expect_val("ld_ready_in_reset", 2, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    expect_val("st_valid_after_reset", 3, 0);
    expect_val("st_busy_after_reset", 5, 0);
    for (int i = 0; i < 16; i++) begin
      cyc();
      rd(4'(i), 4'(15 - i));
      expect_val("reset_rd0", 0, 0);
      expect_val("reset_rd1", 1, 0);
      expect_val("reset_ld_ready", 2, 1);
    end
    cyc(); wr(1, 5, 24'hABCDEF); rd(5, 0);
    expect_val("wr_bypass", 0, 24'hABCDEF);
    expect_val("r0_port1", 1, 0);
    cyc(); wr(0, 0, 0);
    expect_val("wr_stored", 0, 24'hABCDEF);
    cyc(); wr(1, 0, 24'h123456); rd(0, 0);
    expect_val("r0_wr_bypass", 0, 0);
    cyc(); wr(0, 0, 0); ld(1, 0, 24'h777777);
    expect_val("r0_ld_ready", 2, 1);
    expect_val("r0_ld_bypass", 0, 0);
    cyc(); ld(0, 0, 0);
    expect_val("r0_stays_zero", 0, 0);
    cyc(); wr(1, 3, 24'h000011); ld(1, 3, 24'h000022); rd(3, 3);
    expect_val("conflict_ld_ready", 2, 0);
    expect_val("conflict_alu_wins", 0, 24'h000011);
    cyc(); wr(0, 0, 0);
    expect_val("retry_ld_ready", 2, 1);
    expect_val("retry_ld_bypass", 0, 24'h000022);
    cyc(); ld(0, 0, 0);
    expect_val("retry_committed", 0, 24'h000022);
    cyc(); wr(1, 3, 24'h000033); ld(1, 4, 24'h000044); rd(3, 4);
    expect_val("dual_ld_ready", 2, 1);
    cyc(); wr(0, 0, 0); ld(0, 0, 0);
    expect_val("dual_r3", 0, 24'h000033);
    expect_val("dual_r4", 1, 24'h000044);
    cyc(); wr(1, 7, 24'h5A5A5A);
    cyc(); wr(0, 0, 0); st(1, 7, 0); sq.push_back(24'h5A5A5A);
    expect_val("st_latency", 3, 0);
    cyc(); st(0, 7, 0);
    expect_val("st_valid", 3, 1);
    expect_val("st_busy", 5, 1);
    expect_val("st_data", 4, 24'h5A5A5A);
    for (int i = 0; i < 3; i++) begin
      cyc(); wr(1, 7, 0); st(1, 5, 0);
      expect_val("hold_data", 4, 24'h5A5A5A);
      expect_val("hold_valid", 3, 1);
      expect_val("hold_busy", 5, 1);
    end
    cyc(); wr(0, 0, 0); st(1, 5, 1);
    expect_val("ready_cycle_valid", 3, 1);
    cyc(); st(0, 0, 0); rd(7, 7);
    expect_val("accepted_valid", 3, 0);
    expect_val("accepted_busy", 5, 0);
    expect_val("r7_overwritten", 0, 0);
    cyc(); wr(1, 9, 24'hBEEF01); st(1, 9, 0); sq.push_back(24'hBEEF01);
    cyc(); wr(0, 0, 0); st(0, 0, 0);
    expect_val("st_bypass_data", 4, 24'hBEEF01);
    cyc(); rst = 1'b0; rd(9, 5);
    expect_val("async_rst_valid", 3, 0);
    expect_val("async_rst_busy", 5, 0);
    expect_val("async_rst_ld_ready", 2, 0);
    expect_val("async_rst_r9", 0, 0);
    cyc(); rst = 1'b1;
    expect_val("post_rst_valid", 3, 0);
    cyc(); wr(1, 5, 24'hC0FFEE); st(1, 5, 0); sq.push_back(24'hC0FFEE);
    cyc(); wr(0, 0, 0); st(0, 0, 0);
    expect_val("restart_valid", 3, 1);
    expect_val("restart_data", 4, 24'hC0FFEE);
    cyc(); st(0, 0, 1);
    cyc(); st(0, 0, 0);
    expect_val("restart_done", 3, 0);
    @(negedge clk);
    #1;
    checks++;
    if (sq.size() != 0 || q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d stores %0d checks pending expected 0", sq.size(), q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
